// File: rtl/mmio_arbiter_pkg.sv
// mmio_arbiter_pkg: shared types and constants for the mmio arbiter slice.
//   data_width   - access width of an mmio transaction (byte/half/word)
//   arb_state_e  - sequencer state (IDLE / RD_WAIT)
//   master_e     - identifies one of the two bus masters
//   mmio_req_t   - the transaction fields latched toward mmio on a grant
package mmio_arbiter_pkg;

    typedef enum logic [1:0] {
        DB = 2'b00,
        DH = 2'b01,
        DW = 2'b10
    } data_width;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    localparam int MMIO_ARB_TIMEOUT_DEFAULT = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic        sign_ex;
        data_width   dw;
    } mmio_req_t;

endpackage

// File: rtl/mmio_arbiter_if.sv
// mmio_arbiter_if: bus bundle between the two masters, the arbiter and mmio.
//   m0_* / m1_*   - request side (req/addr/wdata/rw/sign_ex/dw in,
//                   gnt/rdata/rvalid/rerr back to the master)
//   io_*          - single-ported mmio side (addr/wdata/rw/en/sign_ex/dw out,
//                   io_read/io_read_ready back from mmio)
//   slave modport  - the arbiter's view
//   master modport - the environment's view (masters plus mmio)
interface mmio_arbiter_if;
    import mmio_arbiter_pkg::*;

    logic        m0_req,     m1_req;
    logic [31:0] m0_addr,    m1_addr;
    logic [31:0] m0_wdata,   m1_wdata;
    logic        m0_rw,      m1_rw;
    logic        m0_sign_ex, m1_sign_ex;
    data_width   m0_dw,      m1_dw;

    logic        m0_gnt,     m1_gnt;
    logic [31:0] m0_rdata,   m1_rdata;
    logic        m0_rvalid,  m1_rvalid;
    logic        m0_rerr,    m1_rerr;

    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_rw;
    logic        io_en;
    logic        io_sign_ex;
    data_width   io_dw;
    logic [31:0] io_read;
    logic        io_read_ready;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_rw, m0_sign_ex, m0_dw,
        input  m1_req, m1_addr, m1_wdata, m1_rw, m1_sign_ex, m1_dw,
        output m0_gnt, m0_rdata, m0_rvalid, m0_rerr,
        output m1_gnt, m1_rdata, m1_rvalid, m1_rerr,
        output io_addr, io_wdata, io_rw, io_en, io_sign_ex, io_dw,
        input  io_read, io_read_ready
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_rw, m0_sign_ex, m0_dw,
        output m1_req, m1_addr, m1_wdata, m1_rw, m1_sign_ex, m1_dw,
        input  m0_gnt, m0_rdata, m0_rvalid, m0_rerr,
        input  m1_gnt, m1_rdata, m1_rvalid, m1_rerr,
        input  io_addr, io_wdata, io_rw, io_en, io_sign_ex, io_dw,
        output io_read, io_read_ready
    );

endinterface

// File: rtl/mmio_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way pick.
//   req0, req1  - pending requests
//   last_gnt    - master granted most recently
//   fixed_prio  - 1: req0 always wins contention; 0: alternate on contention
//   gnt         - one-hot grant ({M1, M0}), all zero when nothing requests
module rr_arbiter2
    import mmio_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  master_e    last_gnt,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req0 && req1) begin
            if (fixed_prio || (last_gnt == M1)) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares the single-ported mmio block between M0 (CPU LSU)
// and M1 (DMA/debug). One mmio transaction is issued per grant; writes may
// issue every cycle, a read parks the sequencer in RD_WAIT until mmio answers
// or TIMEOUT cycles pass, then the response is routed to the read's owner.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - mmio_arbiter_if.slave (master request/response + mmio port)
// Parameters:
//   TIMEOUT    - cycles spent in RD_WAIT before the read completes with rerr
//   FIXED_PRIO - 0: round-robin on contention, 1: M0 always wins
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = MMIO_ARB_TIMEOUT_DEFAULT,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    mmio_arbiter_if.slave  bus
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    master_e       owner_q, owner_d;
    master_e       last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Registered outputs and their next values.
    mmio_req_t     io_q, io_d;
    logic          io_en_q, io_en_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    rerr_q, rerr_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;

    mmio_req_t     m0_fields, m1_fields, win_fields;
    master_e       win_sel;
    logic [1:0]    pick;
    logic          rd_ack, rd_timeout, rd_done, issue;

    assign m0_fields = '{bus.m0_addr, bus.m0_wdata, bus.m0_rw, bus.m0_sign_ex, bus.m0_dw};
    assign m1_fields = '{bus.m1_addr, bus.m1_wdata, bus.m1_rw, bus.m1_sign_ex, bus.m1_dw};

    rr_arbiter2 u_pick (
        .req0       (bus.m0_req),
        .req1       (bus.m1_req),
        .last_gnt   (last_gnt_q),
        .fixed_prio (FIXED_PRIO),
        .gnt        (pick)
    );

    assign win_sel    = pick[1] ? M1 : M0;
    assign win_fields = pick[1] ? m1_fields : m0_fields;

    // An acknowledge on the final counted cycle wins over the timeout.
    assign rd_ack     = (state_q == RD_WAIT) && bus.io_read_ready;
    assign rd_timeout = (state_q == RD_WAIT) && !bus.io_read_ready && (cnt_q == CNT_LAST);
    assign rd_done    = rd_ack || rd_timeout;

    // Arbitration also runs on the edge that leaves RD_WAIT, so the next
    // issue lines up with the read response.
    assign issue = ((state_q == IDLE) || rd_done) && (pick != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= M0;
            last_gnt_q <= M1;
            cnt_q      <= '0;
            io_q       <= '{addr: '0, wdata: '0, rw: 1'b0, sign_ex: 1'b0, dw: DW};
            io_en_q    <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rerr_q     <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            io_q       <= io_d;
            io_en_q    <= io_en_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = '0;
        if (issue) begin
            last_gnt_d = win_sel;
            if (!win_fields.rw) begin
                owner_d = win_sel;
            end
        end
        case (state_q)
            IDLE: begin
                if (issue && !win_fields.rw) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    state_d = (issue && !win_fields.rw) ? RD_WAIT : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_en_d  = issue;
        io_d     = issue ? win_fields : io_q;
        gnt_d    = issue ? pick : 2'b00;
        rvalid_d = '0;
        rerr_d   = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (rd_done) begin
            if (owner_q == M0) begin
                rvalid_d[0] = 1'b1;
                rerr_d[0]   = rd_timeout;
                rdata0_d    = rd_ack ? bus.io_read : '0;
            end else begin
                rvalid_d[1] = 1'b1;
                rerr_d[1]   = rd_timeout;
                rdata1_d    = rd_ack ? bus.io_read : '0;
            end
        end
    end

    assign bus.io_addr    = io_q.addr;
    assign bus.io_wdata   = io_q.wdata;
    assign bus.io_rw      = io_q.rw;
    assign bus.io_sign_ex = io_q.sign_ex;
    assign bus.io_dw      = io_q.dw;
    assign bus.io_en      = io_en_q;
    assign bus.m0_gnt     = gnt_q[0];
    assign bus.m1_gnt     = gnt_q[1];
    assign bus.m0_rvalid  = rvalid_q[0];
    assign bus.m1_rvalid  = rvalid_q[1];
    assign bus.m0_rerr    = rerr_q[0];
    assign bus.m1_rerr    = rerr_q[1];
    assign bus.m0_rdata   = rdata0_q;
    assign bus.m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed scoreboard bench for mmio_arbiter.
// dut0 runs round-robin with TIMEOUT 16, dut1 runs fixed priority.
module tb_mmio_arbiter;
    import mmio_arbiter_pkg::*;

    typedef struct {
        int unsigned cyc;
        bit          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rw;
        bit          sx;
        data_width   dw;
    } gnt_t;

    typedef struct {
        int unsigned cyc;
        bit          m;
        logic [31:0] rdata;
        bit          rerr;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int          checks;
    int          errors;

    gnt_t gq0[$];
    rsp_t rq0[$];
    gnt_t gq1[$];

    mmio_arbiter_if bus0 ();
    mmio_arbiter_if bus1 ();

    mmio_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mmio_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h required no event (cycle %0d)", name, act, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g0(input int unsigned c, input bit m, input logic [31:0] a,
                           input logic [31:0] wd, input bit rw, input bit sx, input data_width dw);
        gq0.push_back('{cyc: c, m: m, addr: a, wdata: wd, rw: rw, sx: sx, dw: dw});
    endtask

    task automatic push_r0(input int unsigned c, input bit m, input logic [31:0] d, input bit e);
        rq0.push_back('{cyc: c, m: m, rdata: d, rerr: e});
    endtask

    task automatic push_g1(input int unsigned c, input bit m, input logic [31:0] a);
        gq1.push_back('{cyc: c, m: m, addr: a, wdata: '0, rw: 1'b1, sx: 1'b0, dw: DW});
    endtask

    // Monitor for dut0: every grant / read completion is matched against the queues.
    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        if (bus0.m0_gnt && bus0.m1_gnt) begin
            bad("dual_gnt", 2'b11);
        end else if (bus0.m0_gnt || bus0.m1_gnt) begin
            if (gq0.size() == 0) begin
                bad("unexpected_gnt", {bus0.m1_gnt, bus0.m0_gnt});
            end else begin
                g = gq0.pop_front();
                chk("gnt_master", bus0.m1_gnt, g.m);
                chk("gnt_cycle", cyc, g.cyc);
                chk("gnt_io_en", bus0.io_en, 1);
                chk("gnt_io_addr", bus0.io_addr, g.addr);
                chk("gnt_io_wdata", bus0.io_wdata, g.wdata);
                chk("gnt_io_rw", bus0.io_rw, g.rw);
                chk("gnt_io_sign_ex", bus0.io_sign_ex, g.sx);
                chk("gnt_io_dw", bus0.io_dw, g.dw);
            end
        end else if (bus0.io_en) begin
            bad("io_en_without_gnt", bus0.io_en);
        end

        if (bus0.m0_rvalid && bus0.m1_rvalid) begin
            bad("dual_rvalid", 2'b11);
        end else if (bus0.m0_rvalid || bus0.m1_rvalid) begin
            if (rq0.size() == 0) begin
                bad("unexpected_rvalid", {bus0.m1_rvalid, bus0.m0_rvalid});
            end else begin
                r = rq0.pop_front();
                chk("rsp_master", bus0.m1_rvalid, r.m);
                chk("rsp_cycle", cyc, r.cyc);
                chk("rsp_rdata", r.m ? bus0.m1_rdata : bus0.m0_rdata, r.rdata);
                chk("rsp_rerr", r.m ? bus0.m1_rerr : bus0.m0_rerr, r.rerr);
            end
        end
    end

    // Monitor for dut1 (fixed priority, writes only).
    always @(negedge clk) begin
        gnt_t g;
        if (bus1.m0_gnt && bus1.m1_gnt) begin
            bad("fp_dual_gnt", 2'b11);
        end else if (bus1.m0_gnt || bus1.m1_gnt) begin
            if (gq1.size() == 0) begin
                bad("fp_unexpected_gnt", {bus1.m1_gnt, bus1.m0_gnt});
            end else begin
                g = gq1.pop_front();
                chk("fp_gnt_master", bus1.m1_gnt, g.m);
                chk("fp_gnt_cycle", cyc, g.cyc);
                chk("fp_io_addr", bus1.io_addr, g.addr);
            end
        end
        if (bus1.m0_rvalid || bus1.m1_rvalid) begin
            bad("fp_unexpected_rvalid", {bus1.m1_rvalid, bus1.m0_rvalid});
        end
    end

    task automatic clear_inputs();
        bus0.m0_req = 0; bus0.m0_addr = '0; bus0.m0_wdata = '0; bus0.m0_rw = 0; bus0.m0_sign_ex = 0; bus0.m0_dw = DB;
        bus0.m1_req = 0; bus0.m1_addr = '0; bus0.m1_wdata = '0; bus0.m1_rw = 0; bus0.m1_sign_ex = 0; bus0.m1_dw = DB;
        bus0.io_read = '0; bus0.io_read_ready = 0;
        bus1.m0_req = 0; bus1.m0_addr = '0; bus1.m0_wdata = '0; bus1.m0_rw = 0; bus1.m0_sign_ex = 0; bus1.m0_dw = DB;
        bus1.m1_req = 0; bus1.m1_addr = '0; bus1.m1_wdata = '0; bus1.m1_rw = 0; bus1.m1_sign_ex = 0; bus1.m1_dw = DB;
        bus1.io_read = '0; bus1.io_read_ready = 0;
    endtask

    initial begin
        int unsigned c;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();

        // Reset state
        #12;
        chk("rst_io_en", bus0.io_en, 0);
        chk("rst_io_dw", bus0.io_dw, DW);
        chk("rst_io_addr", bus0.io_addr, 0);
        chk("rst_gnt", {bus0.m1_gnt, bus0.m0_gnt}, 0);
        chk("rst_rvalid", {bus0.m1_rvalid, bus0.m0_rvalid}, 0);
        chk("rst_rdata", {bus0.m1_rdata, bus0.m0_rdata}, 0);
        chk("rst_fp_io_dw", bus1.io_dw, DW);
        step();
        rst_n = 1'b1;
        step();

        // Both masters write continuously: M0, M1, M0, M1
        c = cyc;
        bus0.m0_addr = 32'h0000_0100; bus0.m0_wdata = 32'h0000_00A0; bus0.m0_rw = 1; bus0.m0_dw = DW;
        bus0.m1_addr = 32'h0000_0200; bus0.m1_wdata = 32'h0000_00B0; bus0.m1_rw = 1; bus0.m1_dw = DH;
        bus0.m0_req = 1; bus0.m1_req = 1;
        push_g0(c + 1, 0, 32'h0000_0100, 32'h0000_00A0, 1, 0, DW);
        push_g0(c + 2, 1, 32'h0000_0200, 32'h0000_00B0, 1, 0, DH);
        push_g0(c + 3, 0, 32'h0000_0100, 32'h0000_00A0, 1, 0, DW);
        push_g0(c + 4, 1, 32'h0000_0200, 32'h0000_00B0, 1, 0, DH);
        step(); step(); step();
        bus0.m0_req = 0;
        step();
        bus0.m1_req = 0;
        step();
        chk("alt_io_en_low", bus0.io_en, 0);

        // M0 single write
        c = cyc;
        bus0.m0_addr = 32'h0001_8004; bus0.m0_wdata = 32'hCAFE_F00D; bus0.m0_rw = 1; bus0.m0_sign_ex = 0; bus0.m0_dw = DW;
        bus0.m0_req = 1;
        push_g0(c + 1, 0, 32'h0001_8004, 32'hCAFE_F00D, 1, 0, DW);
        step();
        bus0.m0_req = 0;
        step(); step();

        // M1 byte read, acknowledged two cycles after the request
        c = cyc;
        bus0.m1_addr = 32'h0001_8010; bus0.m1_wdata = '0; bus0.m1_rw = 0; bus0.m1_sign_ex = 1; bus0.m1_dw = DB;
        bus0.m1_req = 1;
        push_g0(c + 1, 1, 32'h0001_8010, 32'h0, 0, 1, DB);
        push_r0(c + 3, 1, 32'hFFFF_FF80, 0);
        step();
        bus0.m1_req = 0;
        step();
        bus0.io_read = 32'hFFFF_FF80; bus0.io_read_ready = 1;
        step();
        bus0.io_read = '0; bus0.io_read_ready = 0;
        chk("m0_rdata_idle", bus0.m0_rdata, 0);
        step();

        // M0 word read; M1 rdata must hold
        c = cyc;
        bus0.m0_addr = 32'h0001_8020; bus0.m0_wdata = '0; bus0.m0_rw = 0; bus0.m0_sign_ex = 0; bus0.m0_dw = DW;
        bus0.m0_req = 1;
        push_g0(c + 1, 0, 32'h0001_8020, 32'h0, 0, 0, DW);
        push_r0(c + 3, 0, 32'h1234_5678, 0);
        step();
        bus0.m0_req = 0;
        step();
        bus0.io_read = 32'h1234_5678; bus0.io_read_ready = 1;
        step();
        bus0.io_read = '0; bus0.io_read_ready = 0;
        chk("m1_rdata_hold", bus0.m1_rdata, 32'hFFFF_FF80);
        step();

        // M0 read to VGA region times out; pending M1 write issues with rvalid
        c = cyc;
        bus0.m0_addr = 32'h000C_0000; bus0.m0_rw = 0; bus0.m0_dw = DW;
        bus0.m0_req = 1;
        push_g0(c + 1, 0, 32'h000C_0000, 32'h0, 0, 0, DW);
        push_r0(c + 17, 0, 32'h0, 1);
        push_g0(c + 17, 1, 32'h0000_0300, 32'h0000_0055, 1, 0, DW);
        step();
        bus0.m0_req = 0;
        bus0.m1_addr = 32'h0000_0300; bus0.m1_wdata = 32'h0000_0055; bus0.m1_rw = 1; bus0.m1_sign_ex = 0; bus0.m1_dw = DW;
        bus0.m1_req = 1;
        for (int i = 0; i < 40 && cyc < c + 17; i++) step();
        bus0.m1_req = 0;
        step();
        // Late acknowledge while idle must be ignored
        bus0.io_read = 32'hDEAD_BEEF; bus0.io_read_ready = 1;
        step();
        bus0.io_read = '0; bus0.io_read_ready = 0;
        step(); step();
        chk("late_ack_m0_rdata", bus0.m0_rdata, 0);

        // Reset in the middle of a read
        c = cyc;
        bus0.m1_addr = 32'h0000_0040; bus0.m1_wdata = '0; bus0.m1_rw = 0; bus0.m1_dw = DW;
        bus0.m1_req = 1;
        push_g0(c + 1, 1, 32'h0000_0040, 32'h0, 0, 0, DW);
        step();
        bus0.m1_req = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_io_en", bus0.io_en, 0);
        chk("midrst_m1_gnt", bus0.m1_gnt, 0);
        chk("midrst_io_addr", bus0.io_addr, 0);
        chk("midrst_io_dw", bus0.io_dw, DW);
        chk("midrst_rdata", {bus0.m1_rdata, bus0.m0_rdata}, 0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("post_rst_io_en", bus0.io_en, 0);
        c = cyc;
        bus0.m1_addr = 32'h0000_0044; bus0.m1_wdata = 32'h0000_0077; bus0.m1_rw = 1; bus0.m1_dw = DW;
        bus0.m1_req = 1;
        push_g0(c + 1, 1, 32'h0000_0044, 32'h0000_0077, 1, 0, DW);
        step();
        bus0.m1_req = 0;
        step(); step();

        // Fixed priority: M0 holds the port while it keeps requesting
        c = cyc;
        bus1.m0_addr = 32'h0000_0500; bus1.m0_wdata = 32'h5; bus1.m0_rw = 1; bus1.m0_dw = DW;
        bus1.m1_addr = 32'h0000_0600; bus1.m1_wdata = 32'h6; bus1.m1_rw = 1; bus1.m1_dw = DW;
        bus1.m0_req = 1; bus1.m1_req = 1;
        push_g1(c + 1, 0, 32'h0000_0500);
        push_g1(c + 2, 0, 32'h0000_0500);
        push_g1(c + 3, 0, 32'h0000_0500);
        push_g1(c + 4, 1, 32'h0000_0600);
        step(); step(); step();
        bus1.m0_req = 0;
        step();
        bus1.m1_req = 0;
        step(); step(); step();

        chk("gq0_drained", gq0.size(), 0);
        chk("rq0_drained", rq0.size(), 0);
        chk("gq1_drained", gq1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
